// File: rtl/mcd_step_sequencer.sv
// rtl/mcd_step_sequencer.sv - 4-coil stepper sequencer: wave/full/half drive, step-count commands, abort, hold, position
module mcd_step_sequencer #(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int POS_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COUNT_WIDTH-1:0] cmd_steps,
    input  logic                   cmd_dir,
    input  logic [1:0]             cmd_mode,
    input  logic [DIV_WIDTH-1:0]   cmd_period,
    input  logic                   hold_en,
    input  logic                   abort,
    output logic [3:0]             coils,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [POS_WIDTH-1:0]   step_pos
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [2:0]             phase_q;
    logic [3:0]             coils_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;
    logic                   zero_pend_q;
    logic [POS_WIDTH-1:0]   pos_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   reload_q;
    logic [COUNT_WIDTH-1:0] rem_q;
    logic                   dir_q;
    logic                   half_q;

    logic                   accept;
    logic [2:0]             align_phase_d;
    logic [2:0]             step_phase_d;
    logic [DIV_WIDTH-1:0]   reload_d;

    function automatic logic [3:0] pattern(input logic [2:0] p);
        case (p)
            3'd0:    pattern = 4'b0001;
            3'd1:    pattern = 4'b0011;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b1100;
            3'd6:    pattern = 4'b1000;
            default: pattern = 4'b1001;
        endcase
    endfunction

    always_comb begin
        accept        = cmd_valid && (state_q == IDLE);
        reload_d      = (cmd_period == '0) ? '0 : cmd_period - DIV_WIDTH'(1);
        align_phase_d = phase_q;
        case (cmd_mode)
            2'b00:   align_phase_d = {phase_q[2:1], 1'b0};
            2'b01:   align_phase_d = {phase_q[2:1], 1'b1};
            default: align_phase_d = phase_q;
        endcase
        // Wave and full skip the interleaved half positions, so they move two indices per step.
        if (dir_q) begin
            step_phase_d = phase_q - (half_q ? 3'd1 : 3'd2);
        end else begin
            step_phase_d = phase_q + (half_q ? 3'd1 : 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            coils_q     <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            pos_q       <= '0;
            div_q       <= '0;
            reload_q    <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (zero_pend_q) begin
                        done_q <= 1'b1;
                    end
                    if (accept) begin
                        dir_q    <= cmd_dir;
                        half_q   <= cmd_mode[1];
                        reload_q <= reload_d;
                        div_q    <= reload_d;
                        rem_q    <= cmd_steps;
                        phase_q  <= align_phase_d;
                        coils_q  <= pattern(align_phase_d);
                        if (cmd_steps == '0) begin
                            zero_pend_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        coils_q <= hold_en ? pattern(phase_q) : 4'b0000;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (div_q == '0) begin
                        phase_q <= step_phase_d;
                        coils_q <= pattern(step_phase_d);
                        // All-ones is -1: one position count per step regardless of mode.
                        pos_q   <= pos_q + {{(POS_WIDTH-1){dir_q}}, 1'b1};
                        rem_q   <= rem_q - COUNT_WIDTH'(1);
                        div_q   <= reload_q;
                        if (rem_q == COUNT_WIDTH'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - DIV_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign coils     = coils_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign step_pos  = pos_q;

endmodule

// File: tb/tb_mcd_step_sequencer.sv
// tb/tb_mcd_step_sequencer.sv - directed self-checking bench for mcd_step_sequencer
module tb_mcd_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_period;
    logic        hold_en;
    logic        abort;
    logic [3:0]  coils;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [23:0] step_pos;

    int errors = 0;
    int checks = 0;

    mcd_step_sequencer #(
        .DIV_WIDTH  (16),
        .COUNT_WIDTH(16),
        .POS_WIDTH  (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_mode  (cmd_mode),
        .cmd_period(cmd_period),
        .hold_en   (hold_en),
        .abort     (abort),
        .coils     (coils),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .step_pos  (step_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] steps, input logic dir, input logic [1:0] mode,
                        input logic [15:0] period);
        cmd_steps  = steps;
        cmd_dir    = dir;
        cmd_mode   = mode;
        cmd_period = period;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    logic [3:0] wave_exp [5];

    initial begin
        wave_exp[0] = 4'b0010;
        wave_exp[1] = 4'b0100;
        wave_exp[2] = 4'b1000;
        wave_exp[3] = 4'b0001;
        wave_exp[4] = 4'b0010;

        rst        = 1'b1;
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_steps  = 16'($urandom);
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_mode   = 2'($urandom_range(0, 3));
        cmd_period = 16'($urandom);
        hold_en    = 1'($urandom_range(0, 1));
        abort      = 1'($urandom_range(0, 1));
        tick();
        tick();
        check("rst_coils", 32'(coils), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_pos", 32'(step_pos), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_aborted", 32'(aborted), 32'h0);

        rst       = 1'b0;
        cmd_valid = 1'b0;
        hold_en   = 1'b0;
        abort     = 1'b0;

        // Wave, forward, 5 steps every 3 clocks
        send(16'd5, 1'b0, 2'b00, 16'd3);
        check("wave_accept_coils", 32'(coils), 32'h1);
        check("wave_accept_busy", 32'(busy), 32'h1);
        check("wave_accept_ready", 32'(cmd_ready), 32'h0);
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e % 3 == 0) check($sformatf("wave_coils_e%0d", e), 32'(coils), 32'(wave_exp[e/3-1]));
            if (e == 14) begin
                check("wave_busy_e14", 32'(busy), 32'h1);
                check("wave_done_e14", 32'(done), 32'h0);
            end
        end
        check("wave_done", 32'(done), 32'h1);
        check("wave_busy_end", 32'(busy), 32'h0);
        check("wave_pos", 32'(step_pos), 32'd5);
        tick();
        check("wave_idle_coils", 32'(coils), 32'h0);
        check("wave_done_clear", 32'(done), 32'h0);

        // Full, forward, hold on: p2 aligns to p3
        hold_en = 1'b1;
        send(16'd2, 1'b0, 2'b01, 16'd2);
        check("full_align", 32'(coils), 32'b0110);
        tick();
        tick();
        check("full_step1", 32'(coils), 32'b1100);
        tick();
        tick();
        check("full_step2", 32'(coils), 32'b1001);
        check("full_done", 32'(done), 32'h1);
        check("full_pos", 32'(step_pos), 32'd7);
        tick();
        tick();
        check("full_hold", 32'(coils), 32'b1001);
        check("full_idle_busy", 32'(busy), 32'h0);

        // Half, reverse, period 0 acts as 1: p7 -> p6 -> p5 -> p4
        send(16'd3, 1'b1, 2'b10, 16'd0);
        check("half_align", 32'(coils), 32'b1001);
        tick();
        check("half_s1", 32'(coils), 32'b1000);
        tick();
        check("half_s2", 32'(coils), 32'b1100);
        check("half_s2_done", 32'(done), 32'h0);
        tick();
        check("half_s3", 32'(coils), 32'b0100);
        check("half_done", 32'(done), 32'h1);
        check("half_pos", 32'(step_pos), 32'd4);

        // Wave long move, abort seen on edge T+10 after steps at T+4, T+8
        send(16'd100, 1'b0, 2'b00, 16'd4);
        check("abort_accept_coils", 32'(coils), 32'b0100);
        for (int e = 1; e <= 9; e++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_no_done", 32'(done), 32'h0);
        check("abort_pos", 32'(step_pos), 32'd6);
        tick();
        check("abort_clear", 32'(aborted), 32'h0);
        check("abort_hold_coils", 32'(coils), 32'b0001);

        // Abort coincident with a step edge: no step taken
        send(16'd100, 1'b1, 2'b00, 16'd4);
        for (int e = 1; e <= 3; e++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_step_pulse", 32'(aborted), 32'h1);
        check("abort_step_pos", 32'(step_pos), 32'd6);
        tick();
        check("abort_step_coils", 32'(coils), 32'b0001);

        // Zero-step command
        send(16'd0, 1'b0, 2'b00, 16'd5);
        check("zero_accept_done", 32'(done), 32'h0);
        check("zero_ready", 32'(cmd_ready), 32'h1);
        tick();
        check("zero_done", 32'(done), 32'h1);
        check("zero_pos", 32'(step_pos), 32'd6);
        check("zero_coils", 32'(coils), 32'b0001);
        tick();
        check("zero_done_clear", 32'(done), 32'h0);

        // Command presented while busy is ignored
        send(16'd2, 1'b0, 2'b10, 16'd2);
        cmd_valid = 1'b1;
        cmd_steps = 16'd50;
        cmd_dir   = 1'b1;
        tick();
        tick();
        check("busy_cmd_s1", 32'(coils), 32'b0011);
        tick();
        tick();
        cmd_valid = 1'b0;
        check("busy_cmd_s2", 32'(coils), 32'b0010);
        check("busy_cmd_done", 32'(done), 32'h1);
        check("busy_cmd_pos", 32'(step_pos), 32'd8);
        tick();
        check("busy_cmd_idle", 32'(busy), 32'h0);

        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort", 32'(aborted), 32'h0);
        check("idle_abort_pos", 32'(step_pos), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
